// File: rtl/keypad_if.sv
// Keypad decoder signal bundle: scanner-side inputs and decoded key outputs.
// The master drives the column/row pattern; the slave (decoder) returns the key.
interface keypad_if;
   logic [3:0] columnas;
   logic [3:0] filas;
   logic [3:0] key;
   logic       key_valid;
   logic       key_strobe;

   modport master (
      output columnas,
      output filas,
      input  key,
      input  key_valid,
      input  key_strobe
   );

   modport slave (
      input  columnas,
      input  filas,
      output key,
      output key_valid,
      output key_strobe
   );
endinterface

// File: rtl/keypad_decoder.sv
// 4x4 matrix keypad decoder: registered key code, debounced valid flag and a
// one-cycle press strobe. All outputs are registered.
module keypad_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic     clk,
   input  logic     rst,
   keypad_if.slave  kp
);

   localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

   logic [3:0] code;
   logic       hit;

   logic [3:0] key_q,        key_d;
   logic [7:0] cnt_q,        cnt_d;
   logic       key_valid_q,  key_valid_d;
   logic       key_strobe_q, key_strobe_d;

   always_comb begin
      code = 4'b0000;
      hit  = 1'b0;
      case ({kp.columnas, kp.filas})
         8'b0001_1110: begin code = 4'b0001; hit = 1'b1; end
         8'b0001_1101: begin code = 4'b0010; hit = 1'b1; end
         8'b0001_1011: begin code = 4'b0011; hit = 1'b1; end
         8'b0001_0111: begin code = 4'b1010; hit = 1'b1; end
         8'b0010_1110: begin code = 4'b0100; hit = 1'b1; end
         8'b0010_1101: begin code = 4'b0101; hit = 1'b1; end
         8'b0010_1011: begin code = 4'b0110; hit = 1'b1; end
         8'b0010_0111: begin code = 4'b1011; hit = 1'b1; end
         8'b0100_1110: begin code = 4'b0111; hit = 1'b1; end
         8'b0100_1101: begin code = 4'b1000; hit = 1'b1; end
         8'b0100_1011: begin code = 4'b1001; hit = 1'b1; end
         8'b0100_0111: begin code = 4'b1100; hit = 1'b1; end
         8'b1000_1110: begin code = 4'b1110; hit = 1'b1; end
         8'b1000_1101: begin code = 4'b0000; hit = 1'b1; end
         8'b1000_1011: begin code = 4'b1111; hit = 1'b1; end
         8'b1000_0111: begin code = 4'b1101; hit = 1'b1; end
         default:      begin code = 4'b0000; hit = 1'b0; end
      endcase
   end

   // key_q doubles as the previous-cycle code; a non-zero count means the
   // previous cycle decoded a valid key.
   always_comb begin
      key_d = code;
      cnt_d = cnt_q;
      if (!hit) begin
         cnt_d = 8'd0;
      end else if (cnt_q == 8'd0 || code != key_q) begin
         cnt_d = 8'd1;
      end else if (cnt_q < STABLE_MAX) begin
         cnt_d = cnt_q + 8'd1;
      end
      key_valid_d  = hit && (cnt_d == STABLE_MAX);
      key_strobe_d = key_valid_d && !key_valid_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q        <= 4'b0000;
         cnt_q        <= 8'd0;
         key_valid_q  <= 1'b0;
         key_strobe_q <= 1'b0;
      end else begin
         key_q        <= key_d;
         cnt_q        <= cnt_d;
         key_valid_q  <= key_valid_d;
         key_strobe_q <= key_strobe_d;
      end
   end

   assign kp.key        = key_q;
   assign kp.key_valid  = key_valid_q;
   assign kp.key_strobe = key_strobe_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Scoreboard bench for keypad_decoder: expected outputs are queued as each
// input cycle is driven and compared one edge later.
module tb_keypad_decoder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   keypad_if kif ();
   keypad_if kif1 ();

   keypad_decoder #(.STABLE_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kif)
   );

   keypad_decoder #(.STABLE_CYCLES(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .kp  (kif1)
   );

   typedef struct packed {
      logic [3:0] k;
      logic       v;
      logic       s;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // {columnas, filas, expected code}
   logic [11:0] legal [16] = '{
      {4'b0001, 4'b1110, 4'b0001}, {4'b0001, 4'b1101, 4'b0010},
      {4'b0001, 4'b1011, 4'b0011}, {4'b0001, 4'b0111, 4'b1010},
      {4'b0010, 4'b1110, 4'b0100}, {4'b0010, 4'b1101, 4'b0101},
      {4'b0010, 4'b1011, 4'b0110}, {4'b0010, 4'b0111, 4'b1011},
      {4'b0100, 4'b1110, 4'b0111}, {4'b0100, 4'b1101, 4'b1000},
      {4'b0100, 4'b1011, 4'b1001}, {4'b0100, 4'b0111, 4'b1100},
      {4'b1000, 4'b1110, 4'b1110}, {4'b1000, 4'b1101, 4'b0000},
      {4'b1000, 4'b1011, 4'b1111}, {4'b1000, 4'b0111, 4'b1101}
   };

   task automatic drive(input logic r, input logic [3:0] c, input logic [3:0] f,
                        input logic [3:0] ek, input logic ev, input logic es);
      exp_t e;
      @(negedge clk);
      rst          = r;
      kif.columnas = c;
      kif.filas    = f;
      e.k = ek; e.v = ev; e.s = es;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic [3:0] c, input logic [3:0] f,
                         input logic [3:0] ek, input logic ev, input logic es);
      exp_t e;
      @(negedge clk);
      kif1.columnas = c;
      kif1.filas    = f;
      e.k = ek; e.v = ev; e.s = es;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
         e = sb.pop_front();
         checks++;
         if ({kif.key, kif.key_valid, kif.key_strobe} !== e) begin
            errors++;
            $display("FAIL reset cyc %0d: got key=%b v=%b s=%b, expected key=%b v=%b s=%b",
                     i, kif.key, kif.key_valid, kif.key_strobe, e.k, e.v, e.s);
         end
      end
   endtask

   task automatic test_legal();
      exp_t e;
      int   nstr;
      for (int p = 0; p < 16; p++) begin
         drive(1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
         e = sb.pop_front();
         checks++;
         if ({kif.key, kif.key_valid, kif.key_strobe} !== e) begin
            errors++;
            $display("FAIL legal_gap %0d: got key=%b v=%b s=%b, expected key=%b v=%b s=%b",
                     p, kif.key, kif.key_valid, kif.key_strobe, e.k, e.v, e.s);
         end
         nstr = 0;
         for (int i = 0; i < 6; i++) begin
            drive(1'b0, legal[p][11:8], legal[p][7:4], legal[p][3:0], i >= 3, i == 3);
            e = sb.pop_front();
            nstr += int'(kif.key_strobe);
            checks++;
            if ({kif.key, kif.key_valid, kif.key_strobe} !== e) begin
               errors++;
               $display("FAIL legal %0d cyc %0d: got key=%b v=%b s=%b, expected key=%b v=%b s=%b",
                        p, i, kif.key, kif.key_valid, kif.key_strobe, e.k, e.v, e.s);
            end
         end
         checks++;
         if (nstr != 1) begin
            errors++;
            $display("FAIL legal_strobe_count %0d: got %0d strobes, expected 1", p, nstr);
         end
      end
   endtask

   task automatic test_invalid();
      exp_t       e;
      logic [7:0] bad [4] = '{8'b1111_1111, 8'b0000_1110, 8'b0011_1110, 8'b0001_1100};
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, bad[i][7:4], bad[i][3:0], 4'b0000, 1'b0, 1'b0);
         e = sb.pop_front();
         checks++;
         if ({kif.key, kif.key_valid, kif.key_strobe} !== e) begin
            errors++;
            $display("FAIL invalid %b/%b: got key=%b v=%b s=%b, expected key=%b v=%b s=%b",
                     bad[i][7:4], bad[i][3:0], kif.key, kif.key_valid, kif.key_strobe,
                     e.k, e.v, e.s);
         end
      end
   endtask

   task automatic test_bounce();
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) drive(1'b0, 4'b0001, 4'b1110, 4'b0001, 1'b0, 1'b0);
         else            drive(1'b0, 4'b0001, 4'b1111, 4'b0000, 1'b0, 1'b0);
         e = sb.pop_front();
         checks++;
         if ({kif.key, kif.key_valid, kif.key_strobe} !== e) begin
            errors++;
            $display("FAIL bounce cyc %0d: got key=%b v=%b s=%b, expected key=%b v=%b s=%b",
                     i, kif.key, kif.key_valid, kif.key_strobe, e.k, e.v, e.s);
         end
      end
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 4'b0001, 4'b1110, 4'b0001, i >= 3, i == 3);
         e = sb.pop_front();
         checks++;
         if ({kif.key, kif.key_valid, kif.key_strobe} !== e) begin
            errors++;
            $display("FAIL bounce_hold cyc %0d: got key=%b v=%b s=%b, expected key=%b v=%b s=%b",
                     i, kif.key, kif.key_valid, kif.key_strobe, e.k, e.v, e.s);
         end
      end
   endtask

   task automatic test_key_change();
      exp_t e;
      drive(1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 4'b0010, 4'b1101, 4'b0101, i >= 3, i == 3);
         e = sb.pop_front();
         checks++;
         if ({kif.key, kif.key_valid, kif.key_strobe} !== e) begin
            errors++;
            $display("FAIL change_5 cyc %0d: got key=%b v=%b s=%b, expected key=%b v=%b s=%b",
                     i, kif.key, kif.key_valid, kif.key_strobe, e.k, e.v, e.s);
         end
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 4'b1000, 4'b0111, 4'b1101, i >= 3, i == 3);
         e = sb.pop_front();
         checks++;
         if ({kif.key, kif.key_valid, kif.key_strobe} !== e) begin
            errors++;
            $display("FAIL change_D cyc %0d: got key=%b v=%b s=%b, expected key=%b v=%b s=%b",
                     i, kif.key, kif.key_valid, kif.key_strobe, e.k, e.v, e.s);
         end
      end
   endtask

   task automatic test_reset_mid_press();
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 4'b1000, 4'b1011, 4'b1111, i >= 3, i == 3);
         e = sb.pop_front();
         checks++;
         if ({kif.key, kif.key_valid, kif.key_strobe} !== e) begin
            errors++;
            $display("FAIL midrst_pre cyc %0d: got key=%b v=%b s=%b, expected key=%b v=%b s=%b",
                     i, kif.key, kif.key_valid, kif.key_strobe, e.k, e.v, e.s);
         end
      end
      drive(1'b1, 4'b1000, 4'b1011, 4'b0000, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({kif.key, kif.key_valid, kif.key_strobe} !== e) begin
         errors++;
         $display("FAIL midrst_edge: got key=%b v=%b s=%b, expected key=%b v=%b s=%b",
                  kif.key, kif.key_valid, kif.key_strobe, e.k, e.v, e.s);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 4'b1000, 4'b1011, 4'b1111, i >= 3, i == 3);
         e = sb.pop_front();
         checks++;
         if ({kif.key, kif.key_valid, kif.key_strobe} !== e) begin
            errors++;
            $display("FAIL midrst_post cyc %0d: got key=%b v=%b s=%b, expected key=%b v=%b s=%b",
                     i, kif.key, kif.key_valid, kif.key_strobe, e.k, e.v, e.s);
         end
      end
   endtask

   task automatic test_stable_one();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive1(4'b1000, 4'b1101, 4'b0000, 1'b1, i == 0);
         e = sb.pop_front();
         checks++;
         if ({kif1.key, kif1.key_valid, kif1.key_strobe} !== e) begin
            errors++;
            $display("FAIL stable1 cyc %0d: got key=%b v=%b s=%b, expected key=%b v=%b s=%b",
                     i, kif1.key, kif1.key_valid, kif1.key_strobe, e.k, e.v, e.s);
         end
      end
      drive1(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({kif1.key, kif1.key_valid, kif1.key_strobe} !== e) begin
         errors++;
         $display("FAIL stable1_release: got key=%b v=%b s=%b, expected key=%b v=%b s=%b",
                  kif1.key, kif1.key_valid, kif1.key_strobe, e.k, e.v, e.s);
      end
   endtask

   initial begin
      rst           = 1'b1;
      kif.columnas  = 4'b0000;
      kif.filas     = 4'b1111;
      kif1.columnas = 4'b0000;
      kif1.filas    = 4'b1111;
      test_reset();
      test_legal();
      test_invalid();
      test_bounce();
      test_key_change();
      test_reset_mid_press();
      test_stable_one();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_decoder.md
# keypad_decoder

Clocked decoder for a 4x4 matrix keypad (1-2-3-A / 4-5-6-B / 7-8-9-C / *-0-#-D). It combines the column drive pattern with the sensed row pattern to produce a 4-bit key code. It also produces a debounced valid flag and a one-cycle press strobe. It sits between the keypad scanner (which drives `columnas`) and the downstream key consumer.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive clock cycles an identical valid decode must persist before `key_valid` asserts; legal range 1..255.
- `clk`  input  1  single system clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `columnas`  input  4  column drive, active-high, one-hot when a column is being scanned.
- `filas`  input  4  row sense, active-low; exactly one bit low when a key in the driven column is pressed.
- `key`  output  4  registered key code of the current inputs.
- `key_valid`  output  1  high while the current valid decode has been stable for at least `STABLE_CYCLES` cycles.
- `key_strobe`  output  1  one-cycle pulse on the cycle `key_valid` rises.

## Operation
- Combinational decode; format is `columnas` / `filas` -> code.
- `columnas` = 0001:
  - 1110->0001 (1), 1101->0010 (2), 1011->0011 (3), 0111->1010 (A).
- `columnas` = 0010:
  - 1110->0100 (4), 1101->0101 (5), 1011->0110 (6), 0111->1011 (B).
- `columnas` = 0100:
  - 1110->0111 (7), 1101->1000 (8), 1011->1001 (9), 0111->1100 (C).
- `columnas` = 1000:
  - 1110->1110 (*), 1101->0000 (0), 1011->1111 (#), 0111->1101 (D).
- Any other combination is invalid and decodes to code 0000 with an internal `hit`=0. This covers a non-one-hot `columnas` (including 0000 and 1111) and `filas` not having exactly one zero.
- Code 0000 is shared by key "0" (`hit`=1) and "no key / invalid" (`hit`=0). Consumers distinguish them only via `key_valid`.
- Registered `key` = decode of the inputs sampled at each rising edge.
- Stability counter:
  - Loads 1 when `hit`=1 and the decoded code differs from the previous cycle's code, or the previous cycle had `hit`=0.
  - Increments, saturating at `STABLE_CYCLES`, when `hit`=1 and the code is unchanged.
  - Clears to 0 when `hit`=0.
- `key_valid` = registered (counter == `STABLE_CYCLES`) && `hit`.
- `key_strobe` = `key_valid` next value high AND `key_valid` current value low. It fires once per stable press, including when a different key replaces a held key after re-stabilizing.

## Timing
- Reset: on a rising edge with `rst`=1, `key`=0000, `key_valid`=0, `key_strobe`=0, counter=0, previous-code register=0000. Reset has priority over all other updates, including mid-press.
- `key` latency: 1 cycle (inputs at edge N appear on `key` after edge N).
- `key_valid` rises after the `STABLE_CYCLES`-th consecutive edge with an identical valid decode. With `STABLE_CYCLES`=4 and inputs held from edge 1, it is high after edge 4.
- `key_valid` falls after the first edge at which the decode is invalid or changed.
- On a code change without an intervening invalid cycle, `key_valid` drops for at least `STABLE_CYCLES`-1 cycles before reasserting.
- `key_strobe` is high for exactly one cycle, aligned with the first cycle `key_valid` is high.
- No combinational path from inputs to outputs.

## Test plan
- All 16 legal column/row pairs, each held for 6 cycles with `STABLE_CYCLES`=4:
  - `key` matches the Operation table one cycle after the first edge.
  - `key_valid` is high from the 4th cycle onward.
  - `key_strobe` pulses exactly once per pair.
- Invalid inputs produce `key`=0000, `key_valid`=0 and `key_strobe`=0 for all of:
  - `columnas`=1111/`filas`=1111.
  - `columnas`=0000/`filas`=1110.
  - `columnas`=0011/`filas`=1110.
  - `columnas`=0001/`filas`=1100.
- Bounce on 0001/1110: alternate valid and invalid every cycle for 8 cycles, then hold valid.
  - `key_valid` stays 0 during the bounce.
  - `key_valid` rises exactly 4 cycles into the hold, with one strobe.
- Key change: hold "5" (0010/1101) until valid, then switch directly to "D" (1000/0111).
  - `key`=1101 next cycle.
  - `key_valid` low for 3 cycles, then high with a new strobe.
- Reset mid-press: assert `rst` for one cycle while "#" is valid.
  - All outputs are 0 after that edge.
  - `key_valid` reasserts 4 cycles after `rst` deasserts with a strobe.
- `STABLE_CYCLES`=1 on "0" (1000/1101): `key`=0000, `key_valid`=1 and `key_strobe`=1 on the first cycle after the edge.
